// File: rtl/pads_cfg_pkg.sv
// pads_cfg_pkg: shared constants and types for the pad direction config controller
package pads_cfg_pkg;
   localparam int NPADS = 44;
   localparam logic [NPADS-1:0] RESET_OE = 44'hC70003FFFBD;
   localparam logic [2:0] ADDR_IO_LO = 3'd0;
   localparam logic [2:0] ADDR_IO_HI = 3'd1;
   localparam logic [2:0] ADDR_EN_LO = 3'd2;
   localparam logic [2:0] ADDR_EN_HI = 3'd3;
   localparam logic [2:0] ADDR_CTRL  = 3'd4;
   localparam int CTRL_COMMIT   = 0;
   localparam int CTRL_AUTO_CLR = 1;
   localparam int CTRL_CLR_ERR  = 2;
   typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_e;
endpackage

// File: rtl/pads_cfg_settle_timer.sv
// pads_cfg_settle_timer: loadable down-counter, expire while the count is zero
module pads_cfg_settle_timer (
   input  logic       clk,
   input  logic       resetb,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       expire
);
   logic [7:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = load ? load_val : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
      expire = cnt_q == 8'd0;
   end
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) cnt_q <= 8'd0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/pads_cfg_ctrl.sv
// pads_cfg_ctrl: stages pad direction/enable words and applies them to the pad latch
module pads_cfg_ctrl #(
   parameter int NPADS = pads_cfg_pkg::NPADS,
   parameter int SETTLE_CYCLES = 8,
   parameter logic [NPADS-1:0] RESET_OE = pads_cfg_pkg::RESET_OE
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [2:0]       wr_addr,
   input  logic [31:0]      wr_data,
   output logic [NPADS-1:0] cnfg_io,
   output logic [NPADS-1:0] cnfg_en,
   output logic [NPADS-1:0] oe_mirror,
   output logic             busy,
   output logic             cfg_done,
   output logic             wr_err
);
   import pads_cfg_pkg::*;
   state_e state_q, state_d;
   logic [NPADS-1:0] staged_io_q, staged_io_d, staged_en_q, staged_en_d;
   logic [NPADS-1:0] cnfg_en_q, cnfg_en_d, mirror_q, mirror_d;
   logic auto_clr_q, auto_clr_d, err_q, err_d, nop_q, nop_d;
   logic wr_fire, ctrl_wr, commit, go, expire;
   always_comb begin
      wr_ready = state_q == IDLE;
      wr_fire = wr_valid && wr_ready;
      ctrl_wr = wr_fire && wr_addr == ADDR_CTRL;
      commit = ctrl_wr && wr_data[CTRL_COMMIT];
      go = commit && |staged_en_q;
      staged_io_d = staged_io_q;
      staged_en_d = staged_en_q;
      if (wr_fire && wr_addr == ADDR_IO_LO) staged_io_d[31:0] = wr_data;
      if (wr_fire && wr_addr == ADDR_IO_HI) staged_io_d[NPADS-1:32] = wr_data[NPADS-33:0];
      if (wr_fire && wr_addr == ADDR_EN_LO) staged_en_d[31:0] = wr_data;
      if (wr_fire && wr_addr == ADDR_EN_HI) staged_en_d[NPADS-1:32] = wr_data[NPADS-33:0];
      if (state_q == APPLY && auto_clr_q) staged_en_d = '0;
      auto_clr_d = go ? wr_data[CTRL_AUTO_CLR] : auto_clr_q;
      // an illegal-address set takes priority over a clear
      err_d = (wr_fire && wr_addr > ADDR_CTRL) ? 1'b1 : (ctrl_wr && wr_data[CTRL_CLR_ERR]) ? 1'b0 : err_q;
      nop_d = commit && !(|staged_en_q);
      cnfg_en_d = go ? staged_en_q : '0;
      mirror_d = state_q == APPLY ? (cnfg_en_q & staged_io_q) | (~cnfg_en_q & mirror_q) : mirror_q;
      state_d = state_q == IDLE ? (go ? APPLY : IDLE) :
                state_q == APPLY ? SETTLE : (expire ? IDLE : SETTLE);
   end
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) begin
         state_q <= IDLE;
         staged_io_q <= RESET_OE;
         staged_en_q <= '0;
         cnfg_en_q <= '0;
         mirror_q <= RESET_OE;
         auto_clr_q <= 1'b0;
         err_q <= 1'b0;
         nop_q <= 1'b0;
      end else begin
         state_q <= state_d;
         staged_io_q <= staged_io_d;
         staged_en_q <= staged_en_d;
         cnfg_en_q <= cnfg_en_d;
         mirror_q <= mirror_d;
         auto_clr_q <= auto_clr_d;
         err_q <= err_d;
         nop_q <= nop_d;
      end
   pads_cfg_settle_timer u_timer (
      .clk      (clk),
      .resetb   (resetb),
      .load     (state_q == APPLY),
      .load_val (8'(SETTLE_CYCLES - 1)),
      .expire   (expire)
   );
   assign cnfg_io = staged_io_q;
   assign cnfg_en = cnfg_en_q;
   assign oe_mirror = mirror_q;
   assign busy = state_q != IDLE;
   assign cfg_done = nop_q || (state_q == SETTLE && expire);
   assign wr_err = err_q;
endmodule
